// File: rtl/pito_csr_apb_master.sv
// CSR-to-APB3 master bridge: decodes a CSR window onto NUM_SLV slaves, posts writes through a
// FIFO, blocks on reads, and reports slave errors and wait-state timeouts.
module pito_csr_apb_master #(
  parameter int unsigned NUM_SLV      = 4,
  parameter int unsigned REGS_PER_SLV = 32,
  parameter logic [11:0] CSR_BASE     = 12'hF20,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned ADDR_W       = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [11:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              wr_err_o,
  output logic [11:0]       wr_err_addr_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] apb_paddr_o,
  output logic [NUM_SLV-1:0] apb_psel_o,
  output logic              apb_penable_o,
  output logic              apb_pwrite_o,
  output logic [31:0]       apb_pwdata_o,
  input  logic [31:0]       apb_prdata_i,
  input  logic              apb_pready_i,
  input  logic              apb_pslverr_i
);

  localparam int unsigned WinLo = 32'(CSR_BASE);
  localparam int unsigned WinHi = WinLo + NUM_SLV * REGS_PER_SLV;
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WaitW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  function automatic logic in_win(input logic [11:0] a);
    return (32'(a) >= WinLo) && (32'(a) < WinHi);
  endfunction

  function automatic logic [NUM_SLV-1:0] sel_of(input logic [11:0] a);
    int unsigned off;
    off = 32'(a) - WinLo;
    return NUM_SLV'(1) << (off / REGS_PER_SLV);
  endfunction

  function automatic logic [ADDR_W-1:0] paddr_of(input logic [11:0] a);
    int unsigned off;
    off = 32'(a) - WinLo;
    return ADDR_W'((off % REGS_PER_SLV) * 4);
  endfunction

  state_e            state_q;
  logic [WaitW-1:0]  wait_q;
  logic              rd_out_q;
  logic              xfer_write_q;
  logic [11:0]       xfer_addr_q;

  logic [11:0]       fifo_addr_q [FIFO_DEPTH];
  logic [31:0]       fifo_data_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic req_in_win, req_fire, push, pop;
  logic oow_wr, oow_rd, iw_rd;
  logic timeout_hit, acc_done, acc_err;

  assign req_in_win = in_win(req_addr_i);

  // Full test uses the registered count so a same-cycle pop never frees a slot.
  always_comb begin
    req_ready_o = 1'b0;
    if (req_write_i) begin
      req_ready_o = req_in_win ? (cnt_q != CntW'(FIFO_DEPTH)) : 1'b1;
    end else begin
      req_ready_o = req_in_win ? ((cnt_q == '0) && (state_q == StIdle) && !rd_out_q)
                               : !rd_out_q;
    end
  end

  assign req_fire    = req_valid_i & req_ready_o;
  assign push        = req_fire & req_write_i & req_in_win;
  assign iw_rd       = req_fire & ~req_write_i & req_in_win;
  assign oow_wr      = req_fire & req_write_i & ~req_in_win;
  assign oow_rd      = req_fire & ~req_write_i & ~req_in_win;
  assign pop         = (state_q == StIdle) && (cnt_q != '0);
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == WaitW'(TIMEOUT));
  assign acc_done    = apb_pready_i | timeout_hit;
  assign acc_err     = apb_pready_i ? apb_pslverr_i : 1'b1;
  assign busy_o      = (state_q != StIdle) | (cnt_q != '0) | rd_out_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    cnt_d    = cnt_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= req_addr_i;
      fifo_data_q[wr_ptr_q] <= req_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      wait_q        <= '0;
      rd_out_q      <= 1'b0;
      xfer_write_q  <= 1'b0;
      xfer_addr_q   <= '0;
      apb_psel_o    <= '0;
      apb_penable_o <= 1'b0;
      apb_paddr_o   <= '0;
      apb_pwrite_o  <= 1'b0;
      apb_pwdata_o  <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      wr_err_o      <= 1'b0;
      wr_err_addr_o <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      wr_err_o    <= 1'b0;
      if (iw_rd) rd_out_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (pop) begin
            xfer_write_q <= 1'b1;
            xfer_addr_q  <= fifo_addr_q[rd_ptr_q];
            apb_psel_o   <= sel_of(fifo_addr_q[rd_ptr_q]);
            apb_paddr_o  <= paddr_of(fifo_addr_q[rd_ptr_q]);
            apb_pwrite_o <= 1'b1;
            apb_pwdata_o <= fifo_data_q[rd_ptr_q];
            state_q      <= StSetup;
          end else if (iw_rd) begin
            // A read is only accepted with an empty FIFO in IDLE, so it issues at once.
            xfer_write_q <= 1'b0;
            xfer_addr_q  <= req_addr_i;
            apb_psel_o   <= sel_of(req_addr_i);
            apb_paddr_o  <= paddr_of(req_addr_i);
            apb_pwrite_o <= 1'b0;
            apb_pwdata_o <= '0;
            state_q      <= StSetup;
          end
        end
        StSetup: begin
          apb_penable_o <= 1'b1;
          wait_q        <= '0;
          state_q       <= StAccess;
        end
        StAccess: begin
          if (acc_done) begin
            apb_psel_o    <= '0;
            apb_penable_o <= 1'b0;
            apb_paddr_o   <= '0;
            apb_pwrite_o  <= 1'b0;
            apb_pwdata_o  <= '0;
            state_q       <= StIdle;
            if (!xfer_write_q) begin
              rsp_valid_o <= 1'b1;
              rsp_rdata_o <= acc_err ? 32'h0 : apb_prdata_i;
              rsp_err_o   <= acc_err;
              rd_out_q    <= 1'b0;
            end else if (acc_err) begin
              wr_err_o      <= 1'b1;
              wr_err_addr_o <= xfer_addr_q;
            end
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Out-of-window write reported last: it owns the pulse if it collides with an APB error.
      if (oow_wr) begin
        wr_err_o      <= 1'b1;
        wr_err_addr_o <= req_addr_i;
      end
      if (oow_rd) begin
        rsp_valid_o <= 1'b1;
        rsp_rdata_o <= '0;
        rsp_err_o   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pito_csr_apb_master.sv
// Directed self-checking bench for pito_csr_apb_master with a scripted wait-state APB slave.
module tb_pito_csr_apb_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, req_ready_o, req_write_i;
  logic [11:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o, rsp_err_o, wr_err_o, busy_o;
  logic [31:0] rsp_rdata_o;
  logic [11:0] wr_err_addr_o;
  logic [11:0] apb_paddr_o;
  logic [3:0]  apb_psel_o;
  logic        apb_penable_o, apb_pwrite_o;
  logic [31:0] apb_pwdata_o, apb_prdata_i;
  logic        apb_pready_i, apb_pslverr_i;

  int          n_vec = 0;
  int          n_miscmp = 0;
  int          cyc = 0;
  int          ws = 0;
  logic        slv_err = 1'b0;
  logic [31:0] rdata_val = 32'h0;
  int          acc_n = 0;
  int          acc_cycles = 0;
  int          rsp_n = 0, rsp_cyc = 0, werr_n = 0;
  logic [31:0] rsp_data;
  logic        rsp_e;
  logic [3:0]  log_sel[$];
  logic [11:0] log_addr[$];
  logic        log_wr[$];
  logic [31:0] log_data[$];

  assign apb_prdata_i  = rdata_val;
  assign apb_pslverr_i = slv_err;

  pito_csr_apb_master #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .wr_err_o(wr_err_o), .wr_err_addr_o(wr_err_addr_o), .busy_o(busy_o),
    .apb_paddr_o(apb_paddr_o), .apb_psel_o(apb_psel_o), .apb_penable_o(apb_penable_o),
    .apb_pwrite_o(apb_pwrite_o), .apb_pwdata_o(apb_pwdata_o), .apb_prdata_i(apb_prdata_i),
    .apb_pready_i(apb_pready_i), .apb_pslverr_i(apb_pslverr_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Slave model and observers: pready rises on the (ws+1)-th ACCESS cycle.
  always @(negedge clk) begin
    if (apb_psel_o != 4'b0 && apb_penable_o) begin
      acc_cycles++;
      apb_pready_i = (acc_n >= ws);
      acc_n++;
      if (apb_pready_i) begin
        log_sel.push_back(apb_psel_o);
        log_addr.push_back(apb_paddr_o);
        log_wr.push_back(apb_pwrite_o);
        log_data.push_back(apb_pwdata_o);
      end
    end else begin
      apb_pready_i = 1'b0;
      acc_n = 0;
    end
    if (rsp_valid_o) begin
      rsp_n++;
      rsp_cyc  = cyc;
      rsp_data = rsp_rdata_o;
      rsp_e    = rsp_err_o;
    end
    if (wr_err_o) werr_n++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                        output int stalls, output int acc_c);
    @(negedge clk);
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = data;
    stalls = 0;
    #1;
    while (!req_ready_o && stalls < 200) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (!req_ready_o) check("req_accept_timeout", 64'd0, 64'd1);
    acc_c = cyc;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (busy_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) check("idle_timeout", 64'd1, 64'd0);
    @(negedge clk);
  endtask

  // Expected transfer log entry k.
  task automatic check_log(input string tag, input int k, input logic [3:0] sel,
                           input logic [11:0] pa, input logic wr, input logic [31:0] wd);
    if (log_sel.size() <= k) begin
      check({tag, "_present"}, 64'(log_sel.size()), 64'(k + 1));
    end else begin
      check({tag, "_psel"}, 64'(log_sel[k]), 64'(sel));
      check({tag, "_paddr"}, 64'(log_addr[k]), 64'(pa));
      check({tag, "_pwrite"}, 64'(log_wr[k]), 64'(wr));
      check({tag, "_pwdata"}, 64'(log_data[k]), 64'(wd));
    end
  endtask

  logic [11:0] waddr [5];
  logic [31:0] wdat  [5];
  logic [3:0]  wsel  [5];
  logic [11:0] wpa   [5];

  initial begin
    int st, ac, base, r0, e0;
    waddr = '{12'hF22, 12'hF43, 12'hF64, 12'hF85, 12'hF26};
    wdat  = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004, 32'h5555_0005};
    wsel  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    wpa   = '{12'h008, 12'h00C, 12'h010, 12'h014, 12'h018};
    req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    apb_pready_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_psel", 64'(apb_psel_o), 64'd0);
    check("rst_penable", 64'(apb_penable_o), 64'd0);
    check("rst_paddr_pwdata", {20'd0, apb_paddr_o, apb_pwdata_o}, 64'd0);
    check("rst_rsp", {31'd0, rsp_valid_o, rsp_rdata_o}, 64'd0);
    check("rst_werr", {51'd0, wr_err_o, wr_err_addr_o}, 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    rst_n = 1'b1;

    // Single zero-wait write, phase by phase.
    ws = 0;
    do_req(1'b1, 12'hF21, 32'hDEAD_BEEF, st, ac);
    @(negedge clk);
    check("w1_busy_idle", {63'd0, busy_o}, 64'd1);
    check("w1_idle_psel", 64'(apb_psel_o), 64'd0);
    @(negedge clk);
    check("w1_setup", {apb_psel_o, apb_penable_o, apb_pwrite_o, apb_paddr_o},
          {46'd0, 4'b0001, 1'b0, 1'b1, 12'h004});
    check("w1_setup_pwdata", 64'(apb_pwdata_o), 64'hDEAD_BEEF);
    @(negedge clk);
    check("w1_access", {apb_psel_o, apb_penable_o}, {59'd0, 4'b0001, 1'b1});
    @(negedge clk);
    check("w1_done_psel", 64'(apb_psel_o), 64'd0);
    check("w1_done_busy", 64'(busy_o), 64'd0);
    check("w1_no_werr", 64'(werr_n), 64'd0);

    // Read with two wait states.
    ws = 2; rdata_val = 32'h0000_1234;
    r0 = rsp_n;
    do_req(1'b0, 12'hF45, 32'h0, st, ac);
    @(negedge clk);
    check("r1_setup", {apb_psel_o, apb_pwrite_o, apb_paddr_o, apb_pwdata_o},
          {15'd0, 4'b0010, 1'b0, 12'h014, 32'h0});
    wait_idle();
    check("r1_rsp_count", 64'(rsp_n - r0), 64'd1);
    check("r1_latency", 64'(rsp_cyc - ac), 64'd5);
    check("r1_rdata", 64'(rsp_data), 64'h1234);
    check("r1_err", 64'(rsp_e), 64'd0);

    // Five writes queued behind a stalled read: the fifth waits for a free slot.
    log_sel.delete(); log_addr.delete(); log_wr.delete(); log_data.delete();
    ws = 3; rdata_val = 32'hCAFE_0001;
    do_req(1'b0, 12'hF60, 32'h0, st, ac);
    for (int i = 0; i < 5; i++) begin
      do_req(1'b1, waddr[i], wdat[i], st, ac);
      if (i < 4) check($sformatf("burst_w%0d_nostall", i), 64'(st), 64'd0);
      else       check("burst_w4_stalled", 64'(st > 0), 64'd1);
    end
    wait_idle();
    check("burst_rd_rdata", 64'(rsp_data), 64'hCAFE_0001);
    check_log("burst_rd", 0, 4'b0100, 12'h000, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) check_log($sformatf("burst_w%0d", i), i + 1, wsel[i], wpa[i],
                                          1'b1, wdat[i]);
    check("burst_no_werr", 64'(werr_n), 64'd0);

    // Read behind two queued writes is held off until they drain.
    log_sel.delete(); log_addr.delete(); log_wr.delete(); log_data.delete();
    ws = 2; rdata_val = 32'h0BAD_F00D;
    do_req(1'b1, 12'hF30, 32'hA0A0_0000, st, ac);
    do_req(1'b1, 12'hF31, 32'hA0A0_0001, st, ac);
    do_req(1'b0, 12'hF50, 32'h0, st, ac);
    check("ord_rd_stalled", 64'(st > 0), 64'd1);
    check("ord_writes_done_at_accept", 64'(log_sel.size()), 64'd2);
    wait_idle();
    check_log("ord_w0", 0, 4'b0001, 12'h040, 1'b1, 32'hA0A0_0000);
    check_log("ord_w1", 1, 4'b0001, 12'h044, 1'b1, 32'hA0A0_0001);
    check_log("ord_rd", 2, 4'b0010, 12'h040, 1'b0, 32'h0);
    check("ord_rdata", 64'(rsp_data), 64'h0BAD_F00D);

    // Timeout (TIMEOUT = 4): ACCESS lasts five cycles.
    ws = 1000; rdata_val = 32'hFFFF_FFFF;
    acc_cycles = 0;
    do_req(1'b0, 12'hF21, 32'h0, st, ac);
    wait_idle();
    check("to_rd_access_cycles", 64'(acc_cycles), 64'd5);
    check("to_rd_latency", 64'(rsp_cyc - ac), 64'd7);
    check("to_rd_err", 64'(rsp_e), 64'd1);
    check("to_rd_rdata", 64'(rsp_data), 64'd0);
    e0 = werr_n;
    do_req(1'b1, 12'hF27, 32'h7777_7777, st, ac);
    wait_idle();
    check("to_wr_pulse", 64'(werr_n - e0), 64'd1);
    check("to_wr_addr", 64'(wr_err_addr_o), 64'hF27);

    // Slave error on a read.
    ws = 0; slv_err = 1'b1; rdata_val = 32'h5A5A_5A5A;
    do_req(1'b0, 12'hF40, 32'h0, st, ac);
    wait_idle();
    check("slverr_rd_err", 64'(rsp_e), 64'd1);
    check("slverr_rd_rdata", 64'(rsp_data), 64'd0);
    slv_err = 1'b0;

    // Window boundaries and out-of-window accesses.
    base = log_sel.size();
    r0 = rsp_n;
    do_req(1'b0, 12'h300, 32'h0, st, ac);
    wait_idle();
    check("oow_rd_latency", 64'(rsp_cyc - ac), 64'd1);
    check("oow_rd_resp", {rsp_e, rsp_data}, {31'd0, 1'b1, 32'h0});
    check("oow_rd_count", 64'(rsp_n - r0), 64'd1);
    do_req(1'b0, 12'hF1F, 32'h0, st, ac);
    wait_idle();
    check("oow_lo_rd_err", 64'(rsp_e), 64'd1);
    e0 = werr_n;
    do_req(1'b1, 12'hFA0, 32'h1, st, ac);
    wait_idle();
    check("oow_wr_pulse", 64'(werr_n - e0), 64'd1);
    check("oow_wr_addr", 64'(wr_err_addr_o), 64'hFA0);
    check("oow_no_apb", 64'(log_sel.size() - base), 64'd0);
    do_req(1'b1, 12'hF9F, 32'hF9F0_F9F0, st, ac);
    wait_idle();
    check_log("top_edge", base, 4'b1000, 12'h07C, 1'b1, 32'hF9F0_F9F0);

    // Reset during ACCESS with writes still queued.
    ws = 1000;
    base = log_sel.size();
    do_req(1'b1, 12'hF21, 32'h1, st, ac);
    do_req(1'b1, 12'hF22, 32'h2, st, ac);
    do_req(1'b1, 12'hF23, 32'h3, st, ac);
    st = 0;
    while (!(apb_psel_o != 4'b0 && apb_penable_o) && st < 50) begin
      @(negedge clk);
      st++;
    end
    check("rst_mid_in_access", 64'(apb_penable_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_psel", {apb_psel_o, apb_penable_o}, 64'd0);
    check("rst_mid_outputs", {apb_paddr_o, apb_pwdata_o, busy_o}, 64'd0);
    @(negedge clk);
    ws = 0;
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("rst_mid_discard", 64'(log_sel.size() - base), 64'd0);
    check("rst_mid_busy", 64'(busy_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
